// File: rtl/booth_mac_accumulator.sv
// Sums a programmed number of signed products into a signed result; SATURATE_EN selects clamping over wrap.
// Latency: result valid the cycle after the last accepted beat; len==0 goes straight to DONE.
// Backpressure: in_ready only while accumulating; result held in DONE until out_ready.
module booth_mac_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   count;
  logic [LEN_W-1:0]   len_q;
  logic               ovf_q;
  logic               take_start;
  logic               beat;

  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0]        sum;
  logic [ACC_W-1:0]        acc_nxt;
  logic                    ovf_add;

  assign prod_ext = ACC_W'($signed(product));
  assign sum      = acc + prod_ext;
  // Same-sign operands whose sum flips sign have left the representable range.
  assign ovf_add  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef SATURATE_EN
  assign acc_nxt = ovf_add ? (prod_ext[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_nxt = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    beat       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          take_start = 1'b1;
          state_nxt  = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat = 1'b1;
          if (count == len_q - LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (take_start) begin
      acc   <= '0;
      count <= '0;
      len_q <= len;
      ovf_q <= 1'b0;
    end else if (beat) begin
      acc   <= acc_nxt;
      count <= count + LEN_W'(1);
      if (ovf_add) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign acc_out  = acc;
  assign overflow = ovf_q;

endmodule
